melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_sequencer.sv | 170 +++++++++++++++++
 tb/tb_melody_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Seven-note melody sequencer (DO..XI) with timed notes and gaps.
// Optional macro MELODY_LOOP_EN: repeat the melody instead of stopping after XI.
module melody_sequencer #(
    parameter logic [24:0] NOTE_CYCLES = 25'd24_999_999,
    parameter logic [24:0] GAP_CYCLES  = 25'd2_499_999,
    parameter logic [17:0] DO = 18'd190839,
    parameter logic [17:0] RE = 18'd170067,
    parameter logic [17:0] MI = 18'd151514,
    parameter logic [17:0] FA = 18'd143265,
    parameter logic [17:0] SO = 18'd127550,
    parameter logic [17:0] LA = 18'd113635,
    parameter logic [17:0] XI = 18'd101214
) (
    input  logic        system_clock,
    input  logic        system_reset,
    input  logic        start,
    input  logic        stop,
    output logic [17:0] tone_period,
    output logic        tone_enable,
    output logic [2:0]  step_index,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [24:0] cnt_q, cnt_d;
    logic [2:0]  step_q, step_d;
    logic [17:0] period_q, period_d;
    logic        tone_en_q, tone_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    function automatic logic [17:0] note_period(input logic [2:0] idx);
        logic [17:0] p;
        case (idx)
            3'd0:    p = DO;
            3'd1:    p = RE;
            3'd2:    p = MI;
            3'd3:    p = FA;
            3'd4:    p = SO;
            3'd5:    p = LA;
            3'd6:    p = XI;
            default: p = 18'd0;
        endcase
        return p;
    endfunction

    // Next-state and next-output logic; stop always wins over start.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        period_d  = period_q;
        tone_en_d = tone_en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d   = PLAY;
                    cnt_d     = 25'd0;
                    step_d    = 3'd0;
                    period_d  = DO;
                    tone_en_d = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    state_d   = IDLE;
                    cnt_d     = 25'd0;
                    step_d    = 3'd0;
                    period_d  = 18'd0;
                    tone_en_d = 1'b0;
                    busy_d    = 1'b0;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d   = IDLE;
                    cnt_d     = 25'd0;
                    step_d    = 3'd0;
                    period_d  = 18'd0;
                    tone_en_d = 1'b0;
                    busy_d    = 1'b0;
                end else if (cnt_q == NOTE_CYCLES) begin
                    state_d   = GAP;
                    cnt_d     = 25'd0;
                    tone_en_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 25'd1;
                end
            end
            GAP: begin
                if (stop) begin
                    state_d   = IDLE;
                    cnt_d     = 25'd0;
                    step_d    = 3'd0;
                    period_d  = 18'd0;
                    tone_en_d = 1'b0;
                    busy_d    = 1'b0;
                end else if (cnt_q == GAP_CYCLES) begin
                    if (step_q == 3'd6) begin
`ifdef MELODY_LOOP_EN
                        state_d   = PLAY;
                        cnt_d     = 25'd0;
                        step_d    = 3'd0;
                        period_d  = DO;
                        tone_en_d = 1'b1;
`else
                        state_d   = IDLE;
                        cnt_d     = 25'd0;
                        step_d    = 3'd0;
                        period_d  = 18'd0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
`endif
                    end else begin
                        state_d   = PLAY;
                        cnt_d     = 25'd0;
                        step_d    = step_q + 3'd1;
                        period_d  = note_period(step_q + 3'd1);
                        tone_en_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 25'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = 25'd0;
                step_d    = 3'd0;
                period_d  = 18'd0;
                tone_en_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            state_q   <= IDLE;
            cnt_q     <= 25'd0;
            step_q    <= 3'd0;
            period_q  <= 18'd0;
            tone_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            period_q  <= period_d;
            tone_en_q <= tone_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tone_period = period_q;
    assign tone_enable = tone_en_q;
    assign step_index  = step_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer with short note/gap timing.
module tb_melody_sequencer;

    logic        system_clock;
    logic        system_reset;
    logic        start;
    logic        stop;
    logic [17:0] tone_period;
    logic        tone_enable;
    logic [2:0]  step_index;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    melody_sequencer #(
        .NOTE_CYCLES(25'd3),
        .GAP_CYCLES (25'd1)
    ) dut (
        .system_clock(system_clock),
        .system_reset(system_reset),
        .start       (start),
        .stop        (stop),
        .tone_period (tone_period),
        .tone_enable (tone_enable),
        .step_index  (step_index),
        .busy        (busy),
        .done        (done)
    );

    initial system_clock = 1'b0;
    always #5 system_clock = ~system_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [17:0] note_of(input int k);
        case (k)
            0:       return 18'd190839;
            1:       return 18'd170067;
            2:       return 18'd151514;
            3:       return 18'd143265;
            4:       return 18'd127550;
            5:       return 18'd113635;
            6:       return 18'd101214;
            default: return 18'd0;
        endcase
    endfunction

    // Expected {tone_enable, step_index, tone_period, busy, done} at cycle c after a start pulse at cycle 0.
    function automatic logic [31:0] exp_vec(input int c);
        int k;
        int ph;
        int cc;
        cc = c;
`ifdef MELODY_LOOP_EN
        if (cc > 42) cc = ((cc - 1) % 42) + 1;
`endif
        if (cc >= 1 && cc <= 42) begin
            k  = (cc - 1) / 6;
            ph = (cc - 1) % 6;
            return {8'd0, (ph < 4) ? 1'b1 : 1'b0, k[2:0], note_of(k), 1'b1, 1'b0};
        end else if (cc == 43) begin
            return {8'd0, 1'b0, 3'd0, 18'd0, 1'b0, 1'b1};
        end
        return 32'd0;
    endfunction

    function automatic logic [31:0] obs_vec();
        return {8'd0, tone_enable, step_index, tone_period, busy, done};
    endfunction

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic force_idle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        system_reset = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        #1;
        check("reset_async", obs_vec(), 32'd0);
        repeat (3) tick();
        check("reset_held", obs_vec(), 32'd0);
        system_reset = 1'b0;
        tick();
        check("idle_after_reset", obs_vec(), 32'd0);

        // Full melody, then stop (no effect in IDLE unless looping)
        start_pulse();
        for (int c = 1; c <= 44; c++) begin
            check($sformatf("run_c%0d", c), obs_vec(), exp_vec(c));
            tick();
        end
        force_idle();
        check("idle_after_run_stop", obs_vec(), 32'd0);

        // Stop during step 2 PLAY at cycle 15
        start_pulse();
        for (int c = 1; c <= 15; c++) begin
            check($sformatf("pre_stop_c%0d", c), obs_vec(), exp_vec(c));
            if (c < 15) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_abort", obs_vec(), 32'd0);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("stop_no_done", obs_vec(), 32'd0);
        end
        start_pulse();
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("replay_c%0d", c), obs_vec(), exp_vec(c));
            tick();
        end
        force_idle();
        check("replay_stopped", obs_vec(), 32'd0);

        // Start while busy is ignored; start+stop together aborts
        start_pulse();
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("restart_c%0d", c), obs_vec(), exp_vec(c));
            if (c == 10) start = 1'b1;
            if (c == 20) begin
                start = 1'b1;
                stop  = 1'b1;
            end
            tick();
            start = 1'b0;
            stop  = 1'b0;
        end
        check("start_stop_abort", obs_vec(), 32'd0);
        tick();
        check("no_restart", obs_vec(), 32'd0);

        // Async reset mid-GAP at cycle 5
        start_pulse();
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("pre_reset_c%0d", c), obs_vec(), exp_vec(c));
            if (c < 5) tick();
        end
        #3;
        system_reset = 1'b1;
        #1;
        check("reset_mid_gap", obs_vec(), 32'd0);
        #3;
        system_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_after_mid_reset", obs_vec(), 32'd0);
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_in_idle", obs_vec(), 32'd0);
        start_pulse();
        check("fresh_start", obs_vec(), exp_vec(1));
        force_idle();
        check("final_idle", obs_vec(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
